// File: rtl/ifu_fb_ctl.sv
// ifu_fb_ctl: fetch-buffer queue feeding the aligner (ports: F2 fetch in, flush, aligner consume in; fb0/fb1 entries, consume1/2, count, sticky flags out; RV_IFU_FB_BYPASS_EN enables same-cycle bypass)
module ifu_fb_ctl #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ifc_fetch_req_f2,
  input  logic                       ic_hit_f2,
  input  logic [30:0]                ifc_fetch_addr_f2,
  input  logic [DATA_W-1:0]          ic_rd_data_f2,
  input  logic                       ic_access_fault_f2,
  input  logic                       exu_flush_final,
  input  logic                       dec_takenbr,
  input  logic                       aln_consume1,
  input  logic                       aln_consume2,
  output logic [1:0]                 fb_valid,
  output logic [DATA_W-1:0]          fb0_data,
  output logic [DATA_W-1:0]          fb1_data,
  output logic [30:0]                fb0_addr,
  output logic [30:0]                fb1_addr,
  output logic                       fb0_fault,
  output logic                       fb1_fault,
  output logic                       ifu_fb_consume1,
  output logic                       ifu_fb_consume2,
  output logic [$clog2(DEPTH):0]     fb_count,
  output logic                       fb_overflow,
  output logic                       fb_underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
`ifdef RV_IFU_FB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [30:0]       mem_addr [DEPTH];
  logic [DEPTH-1:0]  mem_fault;
  logic [AW-1:0]     wr_ptr, rd_ptr, rd_ptr1;
  logic [CW-1:0]     count, req, eff;
  logic              flush_any, wr, byp, byp_take, full_drop, wr_acc, udf_set;
  always_comb begin
    flush_any       = exu_flush_final | dec_takenbr;
    wr              = ifc_fetch_req_f2 & ic_hit_f2 & ~flush_any;
    req             = aln_consume2 ? CW'(2) : aln_consume1 ? CW'(1) : '0;
    eff             = (req > count) ? count : req;
    byp             = BYP & wr & (count == '0);
    byp_take        = byp & (aln_consume1 | aln_consume2);
    full_drop       = wr & (count == CW'(DEPTH)) & (eff == '0);
    wr_acc          = wr & ~full_drop & ~byp_take;
    udf_set         = (req > count) & ~(byp_take & ~aln_consume2);
    rd_ptr1         = rd_ptr + AW'(1);
    fb_valid        = {count >= CW'(2), byp | (count != '0)} & {2{~flush_any}};
    fb0_data        = byp ? ic_rd_data_f2 : mem_data[rd_ptr];
    fb0_addr        = byp ? ifc_fetch_addr_f2 : mem_addr[rd_ptr];
    fb0_fault       = byp ? ic_access_fault_f2 : mem_fault[rd_ptr];
    fb1_data        = mem_data[rd_ptr1];
    fb1_addr        = mem_addr[rd_ptr1];
    fb1_fault       = mem_fault[rd_ptr1];
    ifu_fb_consume1 = ((eff == CW'(1)) | byp_take) & ~flush_any;
    ifu_fb_consume2 = (eff == CW'(2)) & ~flush_any;
    fb_count        = count;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      fb_overflow  <= 1'b0;
      fb_underflow <= 1'b0;
    end else begin
      fb_overflow  <= fb_overflow | full_drop;
      fb_underflow <= fb_underflow | udf_set;
      if (flush_any) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        wr_ptr <= wr_ptr + AW'(wr_acc);
        rd_ptr <= rd_ptr + AW'(eff);
        count  <= count + CW'(wr_acc) - eff;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_data[wr_ptr]  <= ic_rd_data_f2;
      mem_addr[wr_ptr]  <= ifc_fetch_addr_f2;
      mem_fault[wr_ptr] <= ic_access_fault_f2;
    end
  end
endmodule

// File: tb/tb_ifu_fb_ctl.sv
// tb_ifu_fb_ctl: randomized scoreboard bench for ifu_fb_ctl against a queue-based reference model
module tb_ifu_fb_ctl;
  localparam int DEPTH = 4;
`ifdef RV_IFU_FB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  typedef struct {
    logic [63:0] d;
    logic [30:0] a;
    logic        f;
  } ent_t;
  typedef struct {
    logic [1:0]  v;
    logic [63:0] d0, d1;
    logic [30:0] a0, a1;
    logic        f0, f1, c1, c2, ovf, udf;
    int          cnt;
  } exp_t;
  logic        clk = 1'b0, rst = 1'b1;
  logic        ifc_fetch_req_f2 = 1'b0, ic_hit_f2 = 1'b0, ic_access_fault_f2 = 1'b0;
  logic [30:0] ifc_fetch_addr_f2 = '0;
  logic [63:0] ic_rd_data_f2 = '0;
  logic        exu_flush_final = 1'b0, dec_takenbr = 1'b0, aln_consume1 = 1'b0, aln_consume2 = 1'b0;
  logic [1:0]  fb_valid;
  logic [63:0] fb0_data, fb1_data;
  logic [30:0] fb0_addr, fb1_addr;
  logic        fb0_fault, fb1_fault, ifu_fb_consume1, ifu_fb_consume2, fb_overflow, fb_underflow;
  logic [2:0]  fb_count;
  int          total = 0, bad = 0;
  ent_t        mq[$];
  exp_t        exp_q[$];
  bit          m_ovf, m_udf;
  ifu_fb_ctl #(.DEPTH(DEPTH), .DATA_W(64)) dut (
    .clk(clk), .rst(rst),
    .ifc_fetch_req_f2(ifc_fetch_req_f2), .ic_hit_f2(ic_hit_f2),
    .ifc_fetch_addr_f2(ifc_fetch_addr_f2), .ic_rd_data_f2(ic_rd_data_f2),
    .ic_access_fault_f2(ic_access_fault_f2), .exu_flush_final(exu_flush_final),
    .dec_takenbr(dec_takenbr), .aln_consume1(aln_consume1), .aln_consume2(aln_consume2),
    .fb_valid(fb_valid), .fb0_data(fb0_data), .fb1_data(fb1_data),
    .fb0_addr(fb0_addr), .fb1_addr(fb1_addr), .fb0_fault(fb0_fault), .fb1_fault(fb1_fault),
    .ifu_fb_consume1(ifu_fb_consume1), .ifu_fb_consume2(ifu_fb_consume2),
    .fb_count(fb_count), .fb_overflow(fb_overflow), .fb_underflow(fb_underflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask
  task automatic rst_dut();
    rst = 1'b1;
    {ifc_fetch_req_f2, ic_hit_f2, ic_access_fault_f2, exu_flush_final, dec_takenbr, aln_consume1, aln_consume2} = '0;
    mq.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask
  task automatic step(input bit fr, h, input logic [30:0] a, input logic [63:0] d,
                      input bit f, xf, tb, k1, k2);
    exp_t e;
    ent_t n;
    int   cnt, rq, ef;
    bit   fl, w, bp, bt;
    ifc_fetch_req_f2 = fr; ic_hit_f2 = h; ifc_fetch_addr_f2 = a; ic_rd_data_f2 = d;
    ic_access_fault_f2 = f; exu_flush_final = xf; dec_takenbr = tb;
    aln_consume1 = k1; aln_consume2 = k2;
    cnt = mq.size();
    fl  = xf | tb;
    w   = fr & h & !fl;
    rq  = k2 ? 2 : k1 ? 1 : 0;
    ef  = rq < cnt ? rq : cnt;
    bp  = BYP && w && cnt == 0;
    bt  = bp && rq > 0;
    e.v   = {!fl && cnt >= 2, !fl && (cnt >= 1 || bp)};
    e.d0  = bp ? d : cnt >= 1 ? mq[0].d : '0;
    e.a0  = bp ? a : cnt >= 1 ? mq[0].a : '0;
    e.f0  = bp ? f : cnt >= 1 ? mq[0].f : 1'b0;
    e.d1  = cnt >= 2 ? mq[1].d : '0;
    e.a1  = cnt >= 2 ? mq[1].a : '0;
    e.f1  = cnt >= 2 ? mq[1].f : 1'b0;
    e.c1  = !fl && (ef == 1 || bt);
    e.c2  = !fl && ef == 2;
    e.cnt = cnt;
    e.ovf = m_ovf;
    e.udf = m_udf;
    exp_q.push_back(e);
    if (rq > cnt && !(bt && rq == 1)) m_udf = 1'b1;
    if (fl) mq.delete();
    else begin
      for (int i = 0; i < ef; i++) void'(mq.pop_front());
      if (w && !bt) begin
        if (cnt == DEPTH && ef == 0) m_ovf = 1'b1;
        else begin
          n.d = d; n.a = a; n.f = f;
          mq.push_back(n);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic hit(input logic [30:0] a);
    step(1, 1, a, {$urandom(), $urandom()}, 1'($urandom_range(1)), 0, 0, 0, 0);
  endtask
  task automatic idle();
    step(0, 0, '0, '0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("fb_valid", 64'(fb_valid), 64'(e.v));
        chk("consume1", 64'(ifu_fb_consume1), 64'(e.c1));
        chk("consume2", 64'(ifu_fb_consume2), 64'(e.c2));
        chk("fb_count", 64'(fb_count), 64'(e.cnt));
        chk("overflow", 64'(fb_overflow), 64'(e.ovf));
        chk("underflow", 64'(fb_underflow), 64'(e.udf));
        if (e.v[0]) begin
          chk("fb0_data", fb0_data, e.d0);
          chk("fb0_addr", 64'(fb0_addr), 64'(e.a0));
          chk("fb0_fault", 64'(fb0_fault), 64'(e.f0));
        end
        if (e.v[1]) begin
          chk("fb1_data", fb1_data, e.d1);
          chk("fb1_addr", 64'(fb1_addr), 64'(e.a1));
          chk("fb1_fault", 64'(fb1_fault), 64'(e.f1));
        end
      end
    end
  end
  initial begin
    int pw[4] = '{70, 30, 50, 90};
    int pc[4] = '{30, 70, 50, 10};
    bit xf, tb, k1, k2;
    rst_dut();
    chk("rst_valid", 64'(fb_valid), 64'd0);
    chk("rst_count", 64'(fb_count), 64'd0);
    chk("rst_cons", 64'({ifu_fb_consume1, ifu_fb_consume2}), 64'd0);
    chk("rst_flags", 64'({fb_overflow, fb_underflow}), 64'd0);
    hit(31'h80);
    hit(31'h84);
    hit(31'h88);
    chk("t2_count", 64'(fb_count), 64'd3);
    chk("t2_valid", 64'(fb_valid), 64'd3);
    chk("t2_fb0_addr", 64'(fb0_addr), 64'h80);
    chk("t2_fb1_addr", 64'(fb1_addr), 64'h84);
    hit(31'h8c);
    hit(31'h90);
    chk("t3_overflow", 64'(fb_overflow), 64'd1);
    chk("t3_count", 64'(fb_count), 64'd4);
    repeat (4) step(0, 0, '0, '0, 0, 0, 0, 1, 0);
    idle();
    chk("t3_drained", 64'(fb_valid), 64'd0);
    rst_dut();
    hit(31'h40);
    step(0, 0, '0, '0, 0, 0, 0, 0, 1);
    chk("t4_underflow", 64'(fb_underflow), 64'd1);
    chk("t4_count", 64'(fb_count), 64'd0);
    rst_dut();
    hit(31'h10);
    hit(31'h11);
    hit(31'h12);
    step(1, 1, 31'h13, 64'h1234, 0, 0, 1, 0, 0);
    chk("t5_count", 64'(fb_count), 64'd0);
    rst_dut();
    step(1, 1, 31'h100, 64'hdead_beef, 0, 0, 0, 1, 0);
    chk("t6_count", 64'(fb_count), BYP ? 64'd0 : 64'd1);
    idle();
    for (int p = 0; p < 4; p++) begin
      rst_dut();
      for (int i = 0; i < 600; i++) begin
        xf = $urandom_range(99) < 2;
        tb = $urandom_range(99) < 2;
        k2 = !(xf | tb) && $urandom_range(99) < pc[p] / 2;
        k1 = !(xf | tb) && $urandom_range(99) < pc[p];
        step($urandom_range(99) < pw[p] + 5, $urandom_range(99) < 95, 31'($urandom()),
             {$urandom(), $urandom()}, 1'($urandom_range(1)), xf, tb, k1, k2);
      end
    end
    idle();
    repeat (3) @(posedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
